svm_cfg_master: RTL and testbench
=================================

// Module: svm_cfg_master
// PURPOSE
//  Initiator side of the svm core config bus. Accepts single host register transactions on a
//  valid/ready interface and issues them as cfg_req_vld requests to the core config register file.
//  Collects read data, or applies an optional write read-back check, then returns one response per request.
//  Sits between the host/CSR bridge and the core config register file.
// PARAMETERS
//  ADDR_MAX     16  highest legal cfg register index; requests above it are rejected without a bus access
//  TIMEOUT_CYC  16  cycles spent in WAIT_RD without cfg_data_rd_vld before a timeout response (>=2)
//  WR_VERIFY    1   1: each write is followed by a read-back and compare; 0: writes complete blind
// PORTS
//  clk              in   1   core clock, rising edge
//  rst              in   1   asynchronous reset, active-high
//  host_req_vld     in   1   host request valid
//  host_req_rdy     out  1   high in IDLE only; a transfer occurs when host_req_vld & host_req_rdy
//  host_wr          in   1   1 = write, 0 = read
//  host_addr        in   16  register index
//  host_wdata       in   32  write data
//  host_rsp_vld     out  1   response valid; held until host_rsp_rdy
//  host_rsp_rdy     in   1   host accepts response
//  host_rsp_data    out  32  read data, or read-back data on verify; 0 for blind writes and rejects
//  host_rsp_err     out  2   00 ok, 01 rejected (locked or address), 10 timeout, 11 verify mismatch
//  cfg_req_vld      out  1   one-cycle request strobe to the config register file
//  cfg_data_rb_w    out  1   1 = write, 0 = read back
//  cfg_addr         out  16  register index
//  cfg_data         out  32  write data
//  cfg_data_rd_vld  in   1   read data valid from the register file
//  cfg_rd_data      in   32  read data
//  cfg_done         in   1   config locked; the register file ignores writes while high
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE. Reset mid-transaction drops the request with no response.
//   No cfg_req_vld is issued after reset release until a new host request is accepted.
//  Outputs: all outputs are registered. Request fields are latched on acceptance and held
//   until the transaction returns to IDLE.
//  FSM states: IDLE, ISSUE, VRD, WAIT_RD, RESP.
//   IDLE -> ISSUE on accept.
//   IDLE -> RESP (err 01) when the request is a write while cfg_done=1, or host_addr>ADDR_MAX.
//    No bus access occurs in either reject case.
//   ISSUE: cfg_req_vld=1 for exactly one cycle.
//    Read -> WAIT_RD. Write with WR_VERIFY=0 -> RESP (err 00).
//    Write with WR_VERIFY=1 -> VRD.
//   VRD: cfg_req_vld=1 and cfg_data_rb_w=0 for one cycle at the latched address; then -> WAIT_RD.
//   WAIT_RD: the first cycle with cfg_data_rd_vld=1 captures cfg_rd_data and goes -> RESP.
//    Because rd_vld may be sticky, it is sampled only in WAIT_RD, i.e. starting the cycle after the strobe.
//    For a read, err=00. For a verify, err=00 if the data matches the latched wdata, else 11.
//    If the wait counter reaches TIMEOUT_CYC-1 with no rd_vld -> RESP, err=10, data=0.
//   RESP: host_rsp_vld=1 holds data and err stable. On host_rsp_rdy -> IDLE.
//    host_rsp_vld drops and host_req_rdy rises on the next cycle.
//  Latency (accept edge = cycle 0):
//   blind write rsp_vld at cycle 2; read rsp_vld at cycle 3 with a 1-cycle responder;
//   verified write rsp_vld at cycle 4; reject rsp_vld at cycle 1.
//  Single outstanding transaction. host_req_rdy=0 outside IDLE. No request pipelining.
//  cfg_done is sampled only at acceptance. A rise during a write in flight does not abort it;
//   the responder drops the write and the verify reports a mismatch.
//  The wait counter is $clog2(TIMEOUT_CYC) bits, cleared on WAIT_RD entry, and never wraps.
//   The timeout fires before any wrap.
// TESTING
//  Read addr 6, responder returns 32'h2 on the cycle after the strobe -> rsp at cycle 3, data=2, err=00.
//  Write addr 3 data 32'hA5A5_0000, WR_VERIFY=1, cfg_done=0, echo responder
//   -> one write strobe, then one read strobe, then err=00.
//  Write while cfg_done=1 -> no cfg_req_vld; rsp at cycle 1, err=01.
//  Read addr 17 with ADDR_MAX=16 -> no strobe, err=01.
//  Read with responder silent -> rsp exactly TIMEOUT_CYC cycles after WAIT_RD entry, err=10, data=0.
//  Verify read-back 32'h1 vs written 32'h5 -> err=11, data=1.
//  host_rsp_rdy held low for 5 cycles -> rsp fields stable.
//  rst pulse in WAIT_RD -> no response is issued; the next read completes normally.

Source files
------------

// File: rtl/svm_cfg_master.sv
// -----------------------------------------------------------------------------
// svm_cfg_master
//   Initiator side of the svm core config bus. Takes one host register
//   transaction at a time over a valid/ready handshake and issues it to the
//   core config register file as a one-cycle cfg_req_vld strobe. It collects
//   read data, or runs an optional read-back compare after a write, and then
//   returns exactly one response per accepted request.
//
// Parameters
//   ADDR_MAX     highest legal register index; anything above is rejected
//   TIMEOUT_CYC  cycles allowed in WAIT_RD before a timeout response (>= 2)
//   WR_VERIFY    1: every write is followed by a read-back compare
//
// Ports
//   clk_i              core clock, rising edge
//   rst_i              asynchronous reset, active-high
//   host_req_vld_i     host request valid
//   host_req_rdy_o     high only in IDLE
//   host_wr_i          1 = write, 0 = read
//   host_addr_i        register index
//   host_wdata_i       write data
//   host_rsp_vld_o     response valid, held until host_rsp_rdy_i
//   host_rsp_rdy_i     host accepts the response
//   host_rsp_data_o    read / read-back data, 0 for blind writes, rejects, timeouts
//   host_rsp_err_o     00 ok, 01 rejected, 10 timeout, 11 verify mismatch
//   cfg_req_vld_o      one-cycle request strobe to the register file
//   cfg_data_rb_w_o    1 = write, 0 = read (back)
//   cfg_addr_o         register index
//   cfg_data_o         write data
//   cfg_data_rd_vld_i  read data valid (may be sticky)
//   cfg_rd_data_i      read data
//   cfg_done_i         config locked; the register file ignores writes
// -----------------------------------------------------------------------------
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | ready for a host request
// ISSUE    | request strobe on the bus (read, or the write itself)
// VRD      | read-back strobe after a write
// WAIT_RD  | waiting for read data, bounded by the timeout counter
// RESP     | response presented until the host takes it
// -----------------------------------------------------------------------------
module svm_cfg_master #(
  parameter int ADDR_MAX    = 16,
  parameter int TIMEOUT_CYC = 16,
  parameter int WR_VERIFY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req_vld_i,
  output logic        host_req_rdy_o,
  input  logic        host_wr_i,
  input  logic [15:0] host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_rsp_vld_o,
  input  logic        host_rsp_rdy_i,
  output logic [31:0] host_rsp_data_o,
  output logic [1:0]  host_rsp_err_o,
  output logic        cfg_req_vld_o,
  output logic        cfg_data_rb_w_o,
  output logic [15:0] cfg_addr_o,
  output logic [31:0] cfg_data_o,
  input  logic        cfg_data_rd_vld_i,
  input  logic [31:0] cfg_rd_data_i,
  input  logic        cfg_done_i
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [15:0]   ADDR_MAX_L = 16'(ADDR_MAX);
  localparam bit            VERIFY_EN  = (WR_VERIFY != 0);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_REJ = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_VFY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_VRD     = 3'd2,
    S_WAIT_RD = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t        state_q;
  logic          wr_q;
  logic [CW-1:0] cnt_q;
  logic          host_req_rdy_q;
  logic          host_rsp_vld_q;
  logic [31:0]   host_rsp_data_q;
  logic [1:0]    host_rsp_err_q;
  logic          cfg_req_vld_q;
  logic          cfg_data_rb_w_q;
  logic [15:0]   cfg_addr_q;
  logic [31:0]   cfg_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      wr_q            <= 1'b0;
      cnt_q           <= '0;
      host_req_rdy_q  <= 1'b0;
      host_rsp_vld_q  <= 1'b0;
      host_rsp_data_q <= '0;
      host_rsp_err_q  <= ERR_OK;
      cfg_req_vld_q   <= 1'b0;
      cfg_data_rb_w_q <= 1'b0;
      cfg_addr_q      <= '0;
      cfg_data_q      <= '0;
    end else begin
      // The strobe is a single-cycle pulse unless a transition re-arms it.
      cfg_req_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Ready comes up one cycle after reset release and after each response.
          host_req_rdy_q <= 1'b1;
          if (host_req_vld_i && host_req_rdy_q) begin
            host_req_rdy_q <= 1'b0;
            wr_q           <= host_wr_i;
            cfg_addr_q     <= host_addr_i;
            cfg_data_q     <= host_wdata_i;
            // cfg_done is only looked at here; a later rise does not abort.
            if ((host_wr_i && cfg_done_i) || (host_addr_i > ADDR_MAX_L)) begin
              state_q         <= S_RESP;
              host_rsp_vld_q  <= 1'b1;
              host_rsp_data_q <= '0;
              host_rsp_err_q  <= ERR_REJ;
            end else begin
              state_q         <= S_ISSUE;
              cfg_req_vld_q   <= 1'b1;
              cfg_data_rb_w_q <= host_wr_i;
            end
          end
        end

        S_ISSUE: begin
          if (wr_q && VERIFY_EN) begin
            state_q         <= S_VRD;
            cfg_req_vld_q   <= 1'b1;
            cfg_data_rb_w_q <= 1'b0;
          end else if (wr_q) begin
            state_q         <= S_RESP;
            host_rsp_vld_q  <= 1'b1;
            host_rsp_data_q <= '0;
            host_rsp_err_q  <= ERR_OK;
          end else begin
            state_q <= S_WAIT_RD;
            cnt_q   <= '0;
          end
        end

        S_VRD: begin
          state_q <= S_WAIT_RD;
          cnt_q   <= '0;
        end

        S_WAIT_RD: begin
          // rd_vld may be left high by the responder, so it is only trusted
          // from the cycle after the strobe, which is the first WAIT_RD cycle.
          if (cfg_data_rd_vld_i) begin
            state_q         <= S_RESP;
            host_rsp_vld_q  <= 1'b1;
            host_rsp_data_q <= cfg_rd_data_i;
            if (wr_q && (cfg_rd_data_i != cfg_data_q)) begin
              host_rsp_err_q <= ERR_VFY;
            end else begin
              host_rsp_err_q <= ERR_OK;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q         <= S_RESP;
            host_rsp_vld_q  <= 1'b1;
            host_rsp_data_q <= '0;
            host_rsp_err_q  <= ERR_TO;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_RESP: begin
          if (host_rsp_rdy_i) begin
            state_q        <= S_IDLE;
            host_rsp_vld_q <= 1'b0;
            host_req_rdy_q <= 1'b1;
          end
        end

        default: begin
          state_q        <= S_IDLE;
          host_rsp_vld_q <= 1'b0;
          host_req_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign host_req_rdy_o  = host_req_rdy_q;
  assign host_rsp_vld_o  = host_rsp_vld_q;
  assign host_rsp_data_o = host_rsp_data_q;
  assign host_rsp_err_o  = host_rsp_err_q;
  assign cfg_req_vld_o   = cfg_req_vld_q;
  assign cfg_data_rb_w_o = cfg_data_rb_w_q;
  assign cfg_addr_o      = cfg_addr_q;
  assign cfg_data_o      = cfg_data_q;

endmodule

// File: tb/tb_svm_cfg_master.sv
// Directed bench for svm_cfg_master with default parameters
// (ADDR_MAX=16, TIMEOUT_CYC=16, WR_VERIFY=1). A small register-file model
// answers read strobes one cycle later, echoing stored data, returning a
// fixed word, or staying silent.
module tb_svm_cfg_master;

  localparam int M_ECHO   = 0;
  localparam int M_FIXED  = 1;
  localparam int M_SILENT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req_vld, host_req_rdy, host_wr;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_rsp_vld, host_rsp_rdy;
  logic [31:0] host_rsp_data;
  logic [1:0]  host_rsp_err;
  logic        cfg_req_vld, cfg_data_rb_w;
  logic [15:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_data_rd_vld;
  logic [31:0] cfg_rd_data;
  logic        cfg_done;

  int          rmode;
  logic [31:0] rfixed;
  logic [31:0] mem [32];
  int          nwr, nrd;
  int          nerr = 0;
  int          nchk = 0;

  always #5 clk = ~clk;

  svm_cfg_master #(.ADDR_MAX(16), .TIMEOUT_CYC(16), .WR_VERIFY(1)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .host_req_vld_i   (host_req_vld),
    .host_req_rdy_o   (host_req_rdy),
    .host_wr_i        (host_wr),
    .host_addr_i      (host_addr),
    .host_wdata_i     (host_wdata),
    .host_rsp_vld_o   (host_rsp_vld),
    .host_rsp_rdy_i   (host_rsp_rdy),
    .host_rsp_data_o  (host_rsp_data),
    .host_rsp_err_o   (host_rsp_err),
    .cfg_req_vld_o    (cfg_req_vld),
    .cfg_data_rb_w_o  (cfg_data_rb_w),
    .cfg_addr_o       (cfg_addr),
    .cfg_data_o       (cfg_data),
    .cfg_data_rd_vld_i(cfg_data_rd_vld),
    .cfg_rd_data_i    (cfg_rd_data),
    .cfg_done_i       (cfg_done)
  );

  // Register-file model: drops writes while locked, answers reads next cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_data_rd_vld <= 1'b0;
      cfg_rd_data     <= '0;
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      cfg_data_rd_vld <= 1'b0;
      if (cfg_req_vld && cfg_data_rb_w && !cfg_done) mem[cfg_addr[4:0]] <= cfg_data;
      if (cfg_req_vld && !cfg_data_rb_w && rmode != M_SILENT) begin
        cfg_data_rd_vld <= 1'b1;
        cfg_rd_data     <= (rmode == M_ECHO) ? mem[cfg_addr[4:0]] : rfixed;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nwr <= 0;
      nrd <= 0;
    end else if (cfg_req_vld) begin
      if (cfg_data_rb_w) nwr <= nwr + 1;
      else               nrd <= nrd + 1;
    end
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic        done_rise;
    int          mode;
    logic [31:0] fixed;
    int          hold;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    int          exp_lat;
    int          exp_nwr;
    int          exp_nrd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                     input logic done, input logic done_rise, input int mode,
                     input logic [31:0] fixed, input int hold, input logic [31:0] exp_data,
                     input logic [1:0] exp_err, input int exp_lat, input int exp_nwr,
                     input int exp_nrd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.done = done; v.done_rise = done_rise;
    v.mode = mode; v.fixed = fixed; v.hold = hold; v.exp_data = exp_data;
    v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_nwr = exp_nwr; v.exp_nrd = exp_nrd;
    vecs.push_back(v);
  endtask

  // Issues one request and waits for its response; lat counts cycles from the
  // accept edge (accept edge = cycle 0), -1 if no response arrived.
  task automatic run_vec(input vec_t v, input int idx);
    int w, lat, s_wr, s_rd;
    logic [31:0] d;
    logic [1:0]  e;
    cfg_done = v.done;
    rmode    = v.mode;
    rfixed   = v.fixed;
    d = '0; e = '0;
    @(negedge clk);
    w = 0;
    while (!host_req_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("v%0d_req_rdy", idx), 32'(host_req_rdy), 32'd1);
    if (!host_req_rdy) return;
    s_wr = nwr; s_rd = nrd;
    host_req_vld = 1'b1;
    host_wr      = v.wr;
    host_addr    = v.addr;
    host_wdata   = v.wdata;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    host_req_vld = 1'b0;
    if (v.done_rise) cfg_done = 1'b1;
    while (!host_rsp_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (host_rsp_vld) begin
      d = host_rsp_data;
      e = host_rsp_err;
    end else begin
      lat = -1;
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_data", idx), d, v.exp_data);
    chk($sformatf("v%0d_err", idx), 32'(e), 32'(v.exp_err));
    chk($sformatf("v%0d_wr_strobes", idx), 32'(nwr - s_wr), 32'(v.exp_nwr));
    chk($sformatf("v%0d_rd_strobes", idx), 32'(nrd - s_rd), 32'(v.exp_nrd));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold_vld", idx), 32'(host_rsp_vld), 32'd1);
      chk($sformatf("v%0d_hold_data", idx), host_rsp_data, v.exp_data);
      chk($sformatf("v%0d_hold_err", idx), 32'(host_rsp_err), 32'(v.exp_err));
      chk($sformatf("v%0d_hold_rdy", idx), 32'(host_req_rdy), 32'd0);
    end
    host_rsp_rdy = 1'b1;
    @(negedge clk);
    host_rsp_rdy = 1'b0;
    chk($sformatf("v%0d_rsp_drop", idx), 32'(host_rsp_vld), 32'd0);
    chk($sformatf("v%0d_rdy_rise", idx), 32'(host_req_rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, s_tot;
    logic seen;
    vec_t v;
    rst          = 1'b1;
    host_req_vld = 1'b0;
    host_wr      = 1'b0;
    host_addr    = '0;
    host_wdata   = '0;
    host_rsp_rdy = 1'b0;
    cfg_done     = 1'b0;
    rmode        = M_ECHO;
    rfixed       = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_rdy", 32'(host_req_rdy), 32'd0);
    chk("rst_rsp_vld", 32'(host_rsp_vld), 32'd0);
    chk("rst_rsp_data", host_rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(host_rsp_err), 32'd0);
    chk("rst_cfg_req", 32'(cfg_req_vld), 32'd0);
    chk("rst_cfg_rbw", 32'(cfg_data_rb_w), 32'd0);
    chk("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    chk("rst_cfg_data", cfg_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_rdy", 32'(host_req_rdy), 32'd1);
    chk("post_rst_no_strobe", 32'(nwr + nrd), 32'd0);

    //   wr  addr      wdata         done rise mode      fixed         hold exp_data      err  lat nwr nrd
    add(1'b0, 16'd6,     32'h0,        1'b0, 1'b0, M_FIXED,  32'h2,        0, 32'h2,        2'd0, 3,  0, 1);
    add(1'b1, 16'd3,     32'hA5A5_0000,1'b0, 1'b0, M_ECHO,   32'h0,        0, 32'hA5A5_0000,2'd0, 4,  1, 1);
    add(1'b0, 16'd3,     32'h0,        1'b0, 1'b0, M_ECHO,   32'h0,        0, 32'hA5A5_0000,2'd0, 3,  0, 1);
    add(1'b1, 16'd3,     32'h1234_5678,1'b1, 1'b0, M_ECHO,   32'h0,        0, 32'h0,        2'd1, 1,  0, 0);
    add(1'b0, 16'd3,     32'h0,        1'b0, 1'b0, M_ECHO,   32'h0,        0, 32'hA5A5_0000,2'd0, 3,  0, 1);
    add(1'b0, 16'd17,    32'h0,        1'b0, 1'b0, M_ECHO,   32'h0,        0, 32'h0,        2'd1, 1,  0, 0);
    add(1'b1, 16'd16,    32'hDEAD_BEEF,1'b0, 1'b0, M_ECHO,   32'h0,        0, 32'hDEAD_BEEF,2'd0, 4,  1, 1);
    add(1'b0, 16'd16,    32'h0,        1'b1, 1'b0, M_ECHO,   32'h0,        0, 32'hDEAD_BEEF,2'd0, 3,  0, 1);
    add(1'b0, 16'd5,     32'h0,        1'b0, 1'b0, M_SILENT, 32'h0,        0, 32'h0,        2'd2, 18, 0, 1);
    add(1'b1, 16'd2,     32'h5,        1'b0, 1'b0, M_FIXED,  32'h1,        0, 32'h1,        2'd3, 4,  1, 1);
    add(1'b1, 16'd0,     32'hFFFF_FFFF,1'b0, 1'b0, M_ECHO,   32'h0,        5, 32'hFFFF_FFFF,2'd0, 4,  1, 1);
    add(1'b1, 16'd4,     32'h77,       1'b0, 1'b1, M_ECHO,   32'h0,        0, 32'h0,        2'd3, 4,  1, 1);
    add(1'b0, 16'hFFFF,  32'h0,        1'b0, 1'b0, M_ECHO,   32'h0,        0, 32'h0,        2'd1, 1,  0, 0);
    add(1'b0, 16'd0,     32'h0,        1'b0, 1'b0, M_ECHO,   32'h0,        2, 32'hFFFF_FFFF,2'd0, 3,  0, 1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset pulse while the master sits in WAIT_RD with a silent responder.
    cfg_done = 1'b0;
    rmode    = M_SILENT;
    @(negedge clk);
    w = 0;
    while (!host_req_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rstmid_req_rdy", 32'(host_req_rdy), 32'd1);
    host_req_vld = 1'b1;
    host_wr      = 1'b0;
    host_addr    = 16'd1;
    @(posedge clk);
    @(negedge clk);
    host_req_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_rsp_vld", 32'(host_rsp_vld), 32'd0);
    chk("rstmid_req_rdy_low", 32'(host_req_rdy), 32'd0);
    chk("rstmid_cfg_req", 32'(cfg_req_vld), 32'd0);
    rst   = 1'b0;
    s_tot = nwr + nrd;
    seen  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (host_rsp_vld) seen = 1'b1;
    end
    chk("rstmid_no_response", 32'(seen), 32'd0);
    chk("rstmid_no_strobe", 32'(nwr + nrd - s_tot), 32'd0);

    v.wr = 1'b0; v.addr = 16'd9; v.wdata = '0; v.done = 1'b0; v.done_rise = 1'b0;
    v.mode = M_FIXED; v.fixed = 32'h0BAD_F00D; v.hold = 0; v.exp_data = 32'h0BAD_F00D;
    v.exp_err = 2'd0; v.exp_lat = 3; v.exp_nwr = 0; v.exp_nrd = 1;
    run_vec(v, 99);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
